// File: rtl/dmem_responder.sv
// dmem_responder: stallable data-memory target for the core's dmem port.
// Accepts one load/store at a time on a valid/ready request channel and
// returns a completion on a valid/ready response channel after WAIT_STATES
// wait cycles. The RAM is word-organised with per-byte store enables.
//
// Build option: define DMEM_ERR_CHECK_EN to flag misaligned and
// out-of-range addresses on rsp_err (such requests do not touch memory).
// Without it rsp_err is tied low, addr[1:0] is ignored and the word index
// wraps modulo 2**DEPTH_LOG2.
module dmem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_be,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               busy
);

  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]      be_q, be_d;
  logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [WIDTH-1:0]   mem [DEPTH];

  // Request fields seen by the memory access. With zero wait states the
  // access happens on the accept edge itself, so the live inputs are used
  // while in IDLE and the latched copy otherwise.
  logic               acc_write;
  logic [WIDTH-1:0]   acc_addr;
  logic [WIDTH-1:0]   acc_wdata;
  logic [NB-1:0]      acc_be;
  logic               acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic               enter_resp;
  logic               mem_we;

  assign acc_write = (state_q == S_IDLE) ? req_write : write_q;
  assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == S_IDLE) ? req_be    : be_q;
  assign acc_idx   = acc_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_ERR_CHECK_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   (acc_addr[WIDTH-1:DEPTH_LOG2+2] != '0);
`else
  // Alignment and upper address bits are deliberately ignored here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[WIDTH-1:DEPTH_LOG2+2], acc_addr[1:0]};
  assign acc_err = 1'b0;
`endif

  // Next-state, request capture and response-register logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = WS_CNT;
          state_d = (WS_CNT != 4'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The single memory access happens on the edge that enters RESP.
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    mem_we     = enter_resp && acc_write && !acc_err;
    if (enter_resp) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (!acc_write && !acc_err) ? mem[acc_idx] : '0;
    end
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-masked RAM write; a reset edge suppresses any pending store.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it can map onto memory macros.
    if (!reset && mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (acc_be[b]) mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan cases plus
// randomized loads/stores compared against a word-array reference model.
// Honours DMEM_ERR_CHECK_EN the same way the design does.
module tb_dmem_responder;

  localparam int WIDTH      = 32;
  localparam int DEPTH_LOG2 = 6;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int WS         = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WIDTH-1:0]  req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              rsp_err;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [DEPTH];

  dmem_responder #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WAIT_STATES(WS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: a plain word array indexed by byte address / 4.
  function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, output logic [31:0] rd, output bit err);
    int idx;
    idx = int'((a / 4) % DEPTH);
`ifdef DMEM_ERR_CHECK_EN
    err = (a % 4 != 0) || (a >= DEPTH * 4);
`else
    err = 1'b0;
`endif
    rd = 32'h0;
    if (!err) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        rd = ref_mem[idx];
      end
    end
  endfunction

  // One full transaction; hold = cycles rsp_ready stays low once rsp_valid is up.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd_got, output logic err_got);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          guard;
    int          lat;
    model(w, a, d, be, exp_rd, exp_err);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    rsp_ready = (hold == 0);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);              // accept edge
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    check("req_ready_after_accept", {31'b0, req_ready}, 32'd0);
    // rsp_valid must be seen WS edges after the accept edge, i.e. in the
    // (WS+1)-th clock period counting the one the accept edge opens.
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(WS));
    rd_got  = rsp_rdata;
    err_got = rsp_err;
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;          // must be ignored while busy
      req_addr  = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_err", {31'b0, rsp_err}, {31'b0, exp_err});
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);              // handshake edge
    @(negedge clk);
    check("post_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_rdata", rsp_rdata, 32'h0);
    check("post_err", {31'b0, rsp_err}, 32'd0);
    check("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;

    // Give every word a known value so later loads are fully predictable.
    for (int i = 0; i < DEPTH; i++)
      txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, er);

    // Test-plan sequence.
    txn(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, rd, er);
    check("tp_store_rdata", rd, 32'h0);
    check("tp_store_err", {31'b0, er}, 32'd0);
    txn(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er);
    check("tp_load_deadbeef", rd, 32'hDEADBEEF);
    txn(1'b1, 32'h08, 32'h000000AA, 4'h1, 0, rd, er);
    txn(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er);
    check("tp_load_deadbeaa", rd, 32'hDEADBEAA);
    txn(1'b0, 32'h08, 32'h0, 4'h0, 5, rd, er);
    check("tp_stall_load", rd, 32'hDEADBEAA);
    txn(1'b1, 32'h08, 32'h11223344, 4'h0, 0, rd, er);
    txn(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er);
    check("tp_be0_unchanged", rd, 32'hDEADBEAA);
`ifdef DMEM_ERR_CHECK_EN
    txn(1'b1, 32'h0A, 32'hFFFFFFFF, 4'hF, 0, rd, er);
    check("tp_misaligned_err", {31'b0, er}, 32'd1);
    txn(1'b0, 32'h08, 32'h0, 4'h0, 0, rd, er);
    check("tp_misaligned_nowrite", rd, 32'hDEADBEAA);
    txn(1'b0, 32'h100, 32'h0, 4'h0, 0, rd, er);
    check("tp_range_err", {31'b0, er}, 32'd1);
    check("tp_range_rdata", rd, 32'h0);
`else
    txn(1'b1, 32'h100, 32'h12345678, 4'hF, 0, rd, er);
    txn(1'b0, 32'h00, 32'h0, 4'h0, 0, rd, er);
    check("tp_wrap_load", rd, 32'h12345678);
`endif

    // Reset while in WAIT discards the pending store.
    txn(1'b1, 32'h10, 32'h0BADF00D, 4'hF, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h5555AAAA;
    req_be    = 4'hF;
    @(posedge clk);              // accept edge
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_wait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_wait_busy", {31'b0, busy}, 32'd0);
    check("rst_wait_req_ready", {31'b0, req_ready}, 32'd1);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    check("rst_wait_store_dropped", rd, 32'h0BADF00D);

    // Randomized traffic: mostly in-range aligned, some misaligned/out of range.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, DEPTH * 4 - 1));
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3), rd, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port: the target that answers load/store requests.
- Holds a word-organised RAM and accepts one request at a time over a valid/ready request channel.
- Returns a completion on a valid/ready response channel after a fixed, parameterised number of wait states.
- Replaces the zero-latency dmem when the multicycle/pipelined core needs a stallable memory.

Parameters:
- WIDTH, 32, data and address width.
- DEPTH_LOG2, 6, log2 of number of words (64 words default).
- WAIT_STATES, 2, extra cycles between request accept and response valid (0..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data.
- req_be  in  WIDTH/8  byte enables for stores; bit i writes byte i.
- rsp_valid  out  1  completion present.
- rsp_ready  in  1  requester accepts completion.
- rsp_rdata  out  WIDTH  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, active-high):
  - FSM to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - RAM contents are not cleared.
  - Reset during WAIT or RESP discards the pending request; its store is never performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid&req_ready at an edge: latch write, addr, wdata, be; load wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at the edge where counter==1, transition to RESP.
- RESP entry edge (single point of memory access):
  - Load: rsp_rdata <= mem[word index].
  - Store: bytes with be=1 are written; rsp_rdata <= 0.
  - rsp_err computed.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata/rsp_err held stable until rsp_valid&rsp_ready.
  - On handshake: go to IDLE, rsp_valid=0 next cycle, rsp_rdata/rsp_err cleared to 0.
- Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accept edge.
- Throughput:
  - No back-to-back overlap; minimum spacing between accepts is WAIT_STATES+2 cycles with rsp_ready held high.
  - A req_valid asserted while busy is ignored and must be held by the requester.
- Word index = addr[DEPTH_LOG2+1:2].
- Error conditions (with the optional feature enabled), either one sets the error:
  - addr[1:0]!=0 (misaligned).
  - addr[WIDTH-1:DEPTH_LOG2+2]!=0 (out of range).
- On error: no write, rsp_rdata=0, rsp_err=1, normal latency.
- Store with be=0: completes normally, memory unchanged.
- Read-after-write to the same word in consecutive transactions returns the new data.

Optional Feature:
- Macro: DMEM_ERR_CHECK_EN
- Defined: alignment/range checks active as above; rsp_err reports them.
- Undefined:
  - rsp_err tied 0.
  - addr[1:0] ignored.
  - Upper address bits ignored, so the word index wraps modulo 2^DEPTH_LOG2.
  - All requests perform the access.

Test Plan:
- Reset, then store addr=0x08, wdata=0xDEADBEEF, be=0xF with WAIT_STATES=2, rsp_ready=1 -> rsp_valid high 3 cycles after accept for 1 cycle, rsp_err=0, rsp_rdata=0.
- Load addr=0x08 -> rsp_rdata=0xDEADBEEF.
- Store 0x000000AA to addr=0x08 with be=0x1, then load -> rsp_rdata=0xDEADBEAA.
- Load with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles; req_valid pulses during this window are not accepted (req_ready=0); completion on first rsp_ready=1 cycle.
- DMEM_ERR_CHECK_EN on:
  - Store to addr=0x0A -> rsp_err=1 and mem[2] still 0xDEADBEAA.
  - Load addr=0x100 -> rsp_err=1, rsp_rdata=0.
- DMEM_ERR_CHECK_EN off: store 0x12345678 to addr=0x100 -> load of addr=0x00 returns 0x12345678 (wrap).
- Reset asserted in WAIT during a store of 0x5555AAAA to 0x10 -> next cycle IDLE, rsp_valid=0; subsequent load of 0x10 returns the prior value, not 0x5555AAAA.
